// File: rtl/ps2_rx_event_pkg.sv
// Shared constants and types for the PS/2 receive front-end.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ps2_rx_event_pkg;

    // Prefix bytes folded into the event flags.
    localparam logic [7:0] PS2_EXT0 = 8'hE0;
    localparam logic [7:0] PS2_EXT1 = 8'hE1;
    localparam logic [7:0] PS2_BRK  = 8'hF0;

    // Device responses that are swallowed when no prefix is pending.
    localparam logic [7:0] PS2_RSP_ERR0   = 8'h00;
    localparam logic [7:0] PS2_RSP_BAT    = 8'hAA;
    localparam logic [7:0] PS2_RSP_ECHO   = 8'hEE;
    localparam logic [7:0] PS2_RSP_ACK    = 8'hFA;
    localparam logic [7:0] PS2_RSP_RESEND = 8'hFE;
    localparam logic [7:0] PS2_RSP_ERR1   = 8'hFF;

    // Frame FSM states.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } frame_st_e;

    // Event word: [9] ext, [8] brk, [7:0] scan code.
    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } ps2_ev_t;

    localparam int EV_W = $bits(ps2_ev_t);

    function automatic logic is_dev_resp(input logic [7:0] b);
        return (b == PS2_RSP_ERR0) || (b == PS2_RSP_BAT)    ||
               (b == PS2_RSP_ECHO) || (b == PS2_RSP_ACK)    ||
               (b == PS2_RSP_RESEND) || (b == PS2_RSP_ERR1);
    endfunction

endpackage

// File: rtl/ps2_ev_fifo.sv
// Small synchronous event queue with full/empty tracking and drop-on-full.
// Latency: a write is visible at the head one cycle later; a pop exposes the next entry next cycle.
// Backpressure: a write while full is dropped (ovf pulses) unless a pop happens in the same cycle.
module ps2_ev_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_vld,
    input  logic [WIDTH-1:0] wr_dat,
    output logic             ovf,
    input  logic             rd_rdy,
    output logic             empty,
    output logic [WIDTH-1:0] rd_dat
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             full;
    logic             pop;
    logic             we;

    assign empty  = (cnt_q == '0);
    assign full   = (cnt_q == (PTR_W+1)'(DEPTH));
    assign rd_dat = empty ? '0 : mem_q[rd_ptr_q];

    // Next-state for storage, pointers and occupancy; a pop frees room for a same-cycle write.
    always_comb begin
        pop      = rd_rdy & ~empty;
        we       = wr_vld & (~full | pop);
        ovf      = wr_vld & full & ~pop;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (we) begin
            mem_d[wr_ptr_q] = wr_dat;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({we, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/ps2_rx_event.sv
// PS/2 device-to-host receiver: sync, clock filter, frame FSM, prefix folding, event queue.
// Latency: ~2+FILT_LEN cycles from raw clock fall to sample; stop-bit sample to ev_valid is 2 cycles.
// Backpressure: ev_valid/ev_ready; events arriving with a full queue are dropped and flagged on overflow.
module ps2_rx_event #(
    parameter int FILT_LEN    = 8,
    parameter int TIMEOUT_CYC = 28636,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       ev_valid,
    input  logic       ev_ready,
    output logic [7:0] ev_code,
    output logic       ev_ext,
    output logic       ev_brk,
    output logic       err,
    output logic       overflow
);
    import ps2_rx_event_pkg::*;

    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

    logic                clk_s1_q, clk_s1_d, clk_s2_q, clk_s2_d;
    logic                dat_s1_q, dat_s1_d, dat_s2_q, dat_s2_d;
    logic [FILT_LEN-1:0] filt_sr_q, filt_sr_d;
    logic                filt_clk_q, filt_clk_d;
    logic                ps2_fall;
    logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
    logic                to_hit;
    frame_st_e           st_q, st_d;
    logic [2:0]          bit_cnt_q, bit_cnt_d;
    logic [7:0]          shift_q, shift_d;
    logic                par_ok_q, par_ok_d;
    logic [7:0]          byte_q, byte_d;
    logic                byte_vld_q, byte_vld_d;
    logic                ext_pend_q, ext_pend_d;
    logic                brk_pend_q, brk_pend_d;
    logic                push_vld;
    ps2_ev_t             push_ev;
    ps2_ev_t             head_ev;
    logic                ev_empty;

    // The filter only flips on a full run of identical samples, so the fall strobe lasts one cycle.
    assign ps2_fall = filt_clk_q & (filt_sr_q == '0);
    assign to_hit   = (to_cnt_q == TO_W'(TIMEOUT_CYC));

    // Synchronizers and majority-free run-length clock filter.
    always_comb begin
        clk_s1_d   = ps2_clk;
        clk_s2_d   = clk_s1_q;
        dat_s1_d   = ps2_data;
        dat_s2_d   = dat_s1_q;
        filt_sr_d  = {filt_sr_q[FILT_LEN-2:0], clk_s2_q};
        filt_clk_d = filt_clk_q;
        if (filt_sr_q == '0) begin
            filt_clk_d = 1'b0;
        end else if (&filt_sr_q) begin
            filt_clk_d = 1'b1;
        end
    end

    // Inactivity counter: cleared by every clock fall, saturates at the limit.
    always_comb begin
        to_cnt_d = to_cnt_q;
        if (ps2_fall) begin
            to_cnt_d = '0;
        end else if (!to_hit) begin
            to_cnt_d = to_cnt_q + 1'b1;
        end
    end

    // Frame FSM: start, 8 data LSB first, odd parity, stop; errors and timeout pulse err.
    always_comb begin
        st_d       = st_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        par_ok_d   = par_ok_q;
        byte_d     = byte_q;
        byte_vld_d = 1'b0;
        err        = 1'b0;
        if (ps2_fall) begin
            case (st_q)
                ST_IDLE: begin
                    if (!dat_s2_q) begin
                        st_d      = ST_DATA;
                        bit_cnt_d = 3'd0;
                    end else begin
                        err = 1'b1;
                    end
                end
                ST_DATA: begin
                    shift_d   = {dat_s2_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == 3'd7) begin
                        st_d = ST_PARITY;
                    end
                end
                ST_PARITY: begin
                    par_ok_d = ^{shift_q, dat_s2_q};
                    st_d     = ST_STOP;
                end
                ST_STOP: begin
                    st_d = ST_IDLE;
                    if (dat_s2_q && par_ok_q) begin
                        byte_d     = shift_q;
                        byte_vld_d = 1'b1;
                    end else begin
                        err = 1'b1;
                    end
                end
                default: st_d = ST_IDLE;
            endcase
        end else if ((st_q != ST_IDLE) && to_hit) begin
            st_d = ST_IDLE;
            err  = 1'b1;
        end
    end

    // Prefix decoder: fold E0/E1/F0 into flags, drop bare device responses, push everything else.
    always_comb begin
        ext_pend_d = ext_pend_q;
        brk_pend_d = brk_pend_q;
        push_vld   = 1'b0;
        push_ev    = '{ext: ext_pend_q, brk: brk_pend_q, code: byte_q};
        if (byte_vld_q) begin
            if ((byte_q == PS2_EXT0) || (byte_q == PS2_EXT1)) begin
                ext_pend_d = 1'b1;
            end else if (byte_q == PS2_BRK) begin
                brk_pend_d = 1'b1;
            end else begin
                push_vld   = ext_pend_q | brk_pend_q | ~is_dev_resp(byte_q);
                ext_pend_d = 1'b0;
                brk_pend_d = 1'b0;
            end
        end
    end

    // State registers; the filter and synchronizers reset to the idle-high line level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_s1_q   <= 1'b1;
            clk_s2_q   <= 1'b1;
            dat_s1_q   <= 1'b1;
            dat_s2_q   <= 1'b1;
            filt_sr_q  <= '1;
            filt_clk_q <= 1'b1;
            to_cnt_q   <= '0;
            st_q       <= ST_IDLE;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            par_ok_q   <= 1'b0;
            byte_q     <= '0;
            byte_vld_q <= 1'b0;
            ext_pend_q <= 1'b0;
            brk_pend_q <= 1'b0;
        end else begin
            clk_s1_q   <= clk_s1_d;
            clk_s2_q   <= clk_s2_d;
            dat_s1_q   <= dat_s1_d;
            dat_s2_q   <= dat_s2_d;
            filt_sr_q  <= filt_sr_d;
            filt_clk_q <= filt_clk_d;
            to_cnt_q   <= to_cnt_d;
            st_q       <= st_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            par_ok_q   <= par_ok_d;
            byte_q     <= byte_d;
            byte_vld_q <= byte_vld_d;
            ext_pend_q <= ext_pend_d;
            brk_pend_q <= brk_pend_d;
        end
    end

    ps2_ev_fifo #(
        .WIDTH (EV_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst    (reset),
        .wr_vld (push_vld),
        .wr_dat (push_ev),
        .ovf    (overflow),
        .rd_rdy (ev_ready),
        .empty  (ev_empty),
        .rd_dat (head_ev)
    );

    assign ev_valid = ~ev_empty;
    assign ev_code  = head_ev.code;
    assign ev_ext   = head_ev.ext;
    assign ev_brk   = head_ev.brk;

endmodule
